// File: rtl/filt2_pulse_meas.sv
// Rise/fall strobes and high-pulse length measurement on a filtered level, with a single-entry valid/ready event.
// Optional FILT2_PULSE_MEAS_LIVE_LONG_EN adds long_act, which is asserted during a press once it reaches LONG_TH cycles.
module filt2_pulse_meas #(
  parameter int CNT_W   = 16,
  parameter int LONG_TH = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lvl,
  output logic             rise,
  output logic             fall,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_len,
  output logic             evt_long,
  output logic             evt_sat,
  output logic             ovr,
  input  logic             ovr_clr
`ifdef FILT2_PULSE_MEAS_LIVE_LONG_EN
  ,
  output logic             long_act
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_TH_C = CNT_W'(LONG_TH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? CNT_MAX : c + CNT_ONE;
  endfunction

  function automatic logic is_long(input logic [CNT_W-1:0] len);
    return len >= LONG_TH_C;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sat, sat_nxt;
  logic             rise_nxt, fall_nxt, done;
  logic             accept, load, drop;
`ifdef FILT2_PULSE_MEAS_LIVE_LONG_EN
  logic             la_nxt;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sat_nxt   = sat;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    done      = 1'b0;
`ifdef FILT2_PULSE_MEAS_LIVE_LONG_EN
    la_nxt    = long_act;
`endif
    case (state)
      IDLE: begin
        if (lvl) begin
          state_nxt = HIGH;
          cnt_nxt   = CNT_ONE;
          sat_nxt   = (CNT_ONE == CNT_MAX);
          rise_nxt  = 1'b1;
`ifdef FILT2_PULSE_MEAS_LIVE_LONG_EN
          la_nxt    = is_long(CNT_ONE);
`endif
        end
      end
      HIGH: begin
        if (lvl) begin
          cnt_nxt = sat_inc(cnt);
          sat_nxt = sat | (cnt_nxt == CNT_MAX);
`ifdef FILT2_PULSE_MEAS_LIVE_LONG_EN
          la_nxt  = long_act | is_long(cnt_nxt);
`endif
        end else begin
          // Pulse complete: cnt/sat still hold the final measurement this cycle
          state_nxt = IDLE;
          cnt_nxt   = '0;
          sat_nxt   = 1'b0;
          fall_nxt  = 1'b1;
          done      = 1'b1;
`ifdef FILT2_PULSE_MEAS_LIVE_LONG_EN
          la_nxt    = 1'b0;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        sat_nxt   = 1'b0;
`ifdef FILT2_PULSE_MEAS_LIVE_LONG_EN
        la_nxt    = 1'b0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sat   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
`ifdef FILT2_PULSE_MEAS_LIVE_LONG_EN
      long_act <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sat   <= sat_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
`ifdef FILT2_PULSE_MEAS_LIVE_LONG_EN
      long_act <= la_nxt;
`endif
    end
  end

  // Event entry: a completion loads when the slot is empty or is draining on this edge
  assign accept = evt_valid & evt_ready;
  assign load   = done & (~evt_valid | evt_ready);
  assign drop   = done & evt_valid & ~evt_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_len   <= '0;
      evt_long  <= 1'b0;
      evt_sat   <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      if (load) begin
        evt_valid <= 1'b1;
        evt_len   <= cnt;
        evt_long  <= is_long(cnt);
        evt_sat   <= sat;
      end else if (accept) begin
        evt_valid <= 1'b0;
      end
      if (drop)
        ovr <= 1'b1;
      else if (ovr_clr)
        ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_filt2_pulse_meas.sv
// Scoreboard bench for filt2_pulse_meas: run-length reference model feeds an event queue; monitors compare outputs.
module tb_filt2_pulse_meas;
  localparam int CNT_W   = 4;
  localparam int LONG_TH = 8;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             lvl = 1'b0;
  logic             evt_ready = 1'b0;
  logic             ovr_clr = 1'b0;
  logic             rise, fall, evt_valid, evt_long, evt_sat, ovr;
  logic [CNT_W-1:0] evt_len;
`ifdef FILT2_PULSE_MEAS_LIVE_LONG_EN
  logic             long_act;
  bit               e_la;
`endif

  filt2_pulse_meas #(.CNT_W(CNT_W), .LONG_TH(LONG_TH)) dut (
    .clk(clk), .rst(rst), .lvl(lvl),
    .rise(rise), .fall(fall),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_len(evt_len), .evt_long(evt_long), .evt_sat(evt_sat),
    .ovr(ovr), .ovr_clr(ovr_clr)
`ifdef FILT2_PULSE_MEAS_LIVE_LONG_EN
    , .long_act(long_act)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    bit lng;
    bit sat;
  } evt_t;

  evt_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: length of the current run of high samples and the event slot contents
  int m_run = 0;
  bit m_occ = 1'b0;
  bit m_ovr = 1'b0;
  bit e_rise = 1'b0;
  bit e_fall = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run  = 0;
    m_occ  = 1'b0;
    m_ovr  = 1'b0;
    e_rise = 1'b0;
    e_fall = 1'b0;
`ifdef FILT2_PULSE_MEAS_LIVE_LONG_EN
    e_la   = 1'b0;
`endif
    q.delete();
  endtask

  // Drive one sample, then advance the model to what the next clock edge should produce
  task automatic step(input bit l, input bit r, input bit c);
    evt_t e;
    bit   dn, dropped;
    @(negedge clk);
    rst       = 1'b0;
    lvl       = l;
    evt_ready = r;
    ovr_clr   = c;
    dn      = (m_run > 0) && !l;
    dropped = 1'b0;
    e_rise  = l && (m_run == 0);
    e_fall  = dn;
    if (dn) begin
      e.len = (m_run > CMAX) ? CMAX : m_run;
      e.sat = (m_run >= CMAX);
      e.lng = (e.len >= LONG_TH);
      if (!m_occ || r) begin
        m_occ = 1'b1;
        q.push_back(e);
      end else begin
        dropped = 1'b1;
        m_ovr   = 1'b1;
      end
    end else if (m_occ && r) begin
      m_occ = 1'b0;
    end
    if (c && !dropped) m_ovr = 1'b0;
    m_run = l ? m_run + 1 : 0;
`ifdef FILT2_PULSE_MEAS_LIVE_LONG_EN
    e_la = l && (m_run >= LONG_TH);
`endif
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo, input bit r);
    repeat (hi) step(1'b1, r, 1'b0);
    repeat (lo) step(1'b0, r, 1'b0);
  endtask

  // Per-cycle monitor: strobes, flags and the held payload
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        chk("rst_outs", 32'({rise, fall, evt_valid, evt_len, evt_long, evt_sat, ovr}), 32'd0);
`ifdef FILT2_PULSE_MEAS_LIVE_LONG_EN
        chk("rst_long_act", 32'(long_act), 32'd0);
`endif
      end else begin
        chk("rise", 32'(rise), 32'(e_rise));
        chk("fall", 32'(fall), 32'(e_fall));
        chk("evt_valid", 32'(evt_valid), 32'(m_occ));
        chk("ovr", 32'(ovr), 32'(m_ovr));
`ifdef FILT2_PULSE_MEAS_LIVE_LONG_EN
        chk("long_act", 32'(long_act), 32'(e_la));
`endif
        if (evt_valid === 1'b1) begin
          if (q.size() == 0) begin
            chk("evt_unexpected", 32'(evt_valid), 32'd0);
          end else begin
            chk("hold_len", 32'(evt_len), 32'(q[0].len));
            chk("hold_long", 32'(evt_long), 32'(q[0].lng));
            chk("hold_sat", 32'(evt_sat), 32'(q[0].sat));
          end
        end
      end
    end
  end

  // Handshake monitor: pops the scoreboard when the consumer accepts
  initial begin
    evt_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && evt_valid === 1'b1 && evt_ready === 1'b1) begin
        if (q.size() == 0) begin
          chk("acc_unexpected", 32'(evt_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("acc_len", 32'(evt_len), 32'(e.len));
          chk("acc_long", 32'(evt_long), 32'(e.lng));
          chk("acc_sat", 32'(evt_sat), 32'(e.sat));
        end
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);

    // Basic 5-cycle pulse with a ready consumer
    repeat (5) step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);

    // Long threshold boundary and counter saturation
    pulse(7, 2, 1'b1);
    pulse(8, 2, 1'b1);
    pulse(20, 2, 1'b1);
    pulse(15, 2, 1'b1);

    // Backpressure: first event held, second dropped, ovr sticky until cleared
    pulse(3, 2, 1'b0);
    pulse(4, 2, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);

    // Completion on the accepting edge, then drop coinciding with ovr_clr
    pulse(2, 1, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);

    // Reset in the middle of a pulse, released while lvl is still high
    repeat (4) step(1'b1, 1'b1, 1'b0);
    do_reset(2);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b1, 1'b0);

    // Randomized pulses, gaps, backpressure and clears
    for (int i = 0; i < 40; i++) begin
      int hi, lo;
      hi = int'($urandom_range(1, 20));
      lo = int'($urandom_range(1, 4));
      repeat (hi) step(1'b1, $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
      repeat (lo) step(1'b0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
    end

    repeat (3) step(1'b0, 1'b1, 1'b0);
    chk("q_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
